next_sram_writer: RTL
=====================

Name: next_sram_writer

Overview:
Write-side front end for the 256-entry x 4-bit "next" SRAM, which is organised as 16 words of 16 lanes. Accepts a stream of single-entry updates (8-bit entry index, 4-bit value) over a valid/ready handshake. Coalesces consecutive updates to the same word into one lane-masked write, then drives the SRAM write port (wsb, wdata, bytemask, waddr). Sits between the graph-update logic and the next SRAM; the read side of the SRAM is untouched.

Parameters:
ADDR_SPACE, 4, SRAM word-address width (16 words)
Q, 16, lanes per word
BW, 4, bits per lane
TIMEOUT, 8, idle cycles before a pending word is auto-written; 0 disables auto-write

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-high
in_valid  in  1  update valid
in_ready  out  1  update accepted when in_valid && in_ready
in_idx  in  ADDR_SPACE+$clog2(Q)  entry index; upper ADDR_SPACE bits = word, lower bits = lane
in_data  in  BW  entry value
flush  in  1  single-cycle request to write out any pending word
flush_done  out  1  one-cycle pulse: flush complete
pending  out  1  buffer holds unwritten data
wsb  out  1  SRAM write strobe, active-low
wdata  out  BW*Q  SRAM write data; lane i = wdata[BW*i +: BW]
bytemask  out  Q  SRAM lane mask, active-low; bit i = 0 means lane i is written
waddr  out  ADDR_SPACE  SRAM write word address

Behaviour:
- Reset (async, active-high): wsb=1, wdata=0, bytemask all ones, waddr=0, flush_done=0, pending=0, state IDLE, idle counter=0, buffer cleared.
- All SRAM-side outputs and flush_done are registered.
- in_ready = ~flush (combinational). Any cycle without flush accepts input.
- Internal buffer: word address, BW*Q data, Q-bit written-lane set. "pending" = state ACCUM.
- Default each cycle: wsb=1, bytemask all ones. A write is exactly one cycle of wsb=0 carrying the buffer contents.
- States:
  - IDLE:
    - accept -> load buffer (word, lane data, lane set = {lane}), counter=0, go ACCUM.
    - flush -> flush_done=1 next cycle, no write.
  - ACCUM, checked in priority order:
    1. flush -> emit write of buffer, flush_done=1 in the same output cycle as wsb=0, go IDLE. The buffer is invalidated.
    2. accept, same word -> merge lane; a later value to the same lane overwrites the earlier one. counter=0.
    3. accept, different word -> emit write of old buffer; reload buffer with the new entry; stay ACCUM; counter=0.
    4. no accept, TIMEOUT!=0 and counter==TIMEOUT-1 -> emit write, go IDLE.
    5. otherwise counter += 1.
- Emitted write fields:
  - waddr = buffer word.
  - wdata = buffer data; unwritten lanes are driven 0.
  - bytemask[i] = ~lane_set[i].
- Latency: wsb=0 appears on the cycle after the triggering edge; the SRAM commits at the following edge. Total 2 cycles from the trigger to data stored.
- No back-to-back hazard: at most one write per cycle, and a reload never loses data.
- Reset mid-accumulation: pending data is discarded and no write is emitted. This is intended.
- Consumers must not read a word while pending=1 and waddr matches; reader-side arbitration handles this, not this block.

Decomposition:
- Shared package next_sram_pkg holds:
  - NEXT_ADDR_SPACE=4, NEXT_Q=16, NEXT_BW=4.
  - NEXT_IDX_W=8.
  - Localparams for the word/lane split of an index.
  - A state enum {IDLE, ACCUM}.
- One natural sub-module: next_lane_merge. It is combinational: given buffer data, lane set, lane, and value, it returns the updated data and lane set. The FSM, counter, and output registers stay in the top module.

Test Plan:
- Single update idx=0x25, data=0xA, then 8 idle cycles -> one write: waddr=2, wdata lane5=0xA, bytemask=0xFFDF, wsb low exactly 1 cycle; pending falls.
- Updates idx 0x30..0x3F with data=idx[3:0] back-to-back, then flush -> a single write: waddr=3, wdata=0xFEDCBA9876543210, bytemask=0x0000; flush_done coincident with wsb=0.
- idx=0x11 data=0x3, then idx=0x11 data=0x7, then idx=0x40 data=0x1 -> write waddr=1, lane1=0x7, bytemask=0xFFFD; buffer now holds word 4 lane0, pending=1.
- flush asserted with in_valid=1 idx=0x52 -> in_ready=0 that cycle; the pending word is flushed; the 0x52 update is accepted only when presented again.
- flush while IDLE -> flush_done pulse one cycle later, wsb stays 1.
- Assert rst asynchronously mid-ACCUM (between clock edges) -> outputs return to reset values immediately; no write is emitted after release. With the memory model connected, contents are unchanged.

Source files
------------

// File: rtl/next_sram_pkg.sv
// Shared types and geometry for the "next" SRAM write path.
// 256 entries x 4 bits, organised as 16 words of 16 lanes.
package next_sram_pkg;

  localparam int NEXT_ADDR_SPACE = 4;
  localparam int NEXT_Q          = 16;
  localparam int NEXT_BW         = 4;
  localparam int NEXT_IDX_W      = 8;

  // An index splits into {word, lane}; the lane is the low part.
  localparam int NEXT_LANE_W   = $clog2(NEXT_Q);
  localparam int NEXT_LANE_LSB = 0;
  localparam int NEXT_WORD_LSB = NEXT_LANE_W;

  typedef enum logic {
    IDLE,
    ACCUM
  } next_state_e;

endpackage

// File: rtl/next_lane_merge.sv
// Drops one lane value into a word image and marks the lane written.
// A later value to a lane overwrites the earlier one.
module next_lane_merge
  import next_sram_pkg::*;
#(
  parameter int Q  = NEXT_Q,
  parameter int BW = NEXT_BW
) (
  input  logic [BW*Q-1:0]      cur_data,
  input  logic [Q-1:0]         cur_set,
  input  logic [$clog2(Q)-1:0] lane,
  input  logic [BW-1:0]        value,
  output logic [BW*Q-1:0]      new_data,
  output logic [Q-1:0]         new_set
);

  // Overlay the selected lane onto the current image.
  always_comb begin
    new_data = cur_data;
    new_set  = cur_set;
    new_data[lane*BW +: BW] = value;
    new_set[lane] = 1'b1;
  end

endmodule

// File: rtl/next_sram_writer.sv
// Coalesces single-entry updates into lane-masked word writes
// and drives the write port of the next SRAM.
module next_sram_writer
  import next_sram_pkg::*;
#(
  parameter int ADDR_SPACE = NEXT_ADDR_SPACE,
  parameter int Q          = NEXT_Q,
  parameter int BW         = NEXT_BW,
  parameter int TIMEOUT    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ADDR_SPACE+$clog2(Q)-1:0] in_idx,
  input  logic [BW-1:0]                 in_data,
  input  logic                          flush,
  output logic                          flush_done,
  output logic                          pending,
  output logic                          wsb,
  output logic [BW*Q-1:0]               wdata,
  output logic [Q-1:0]                  bytemask,
  output logic [ADDR_SPACE-1:0]         waddr
);

  localparam int LW = $clog2(Q);
  localparam int IW = ADDR_SPACE + LW;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  next_state_e           state, state_d;
  logic [ADDR_SPACE-1:0] buf_word, buf_word_d;
  logic [BW*Q-1:0]       buf_data, buf_data_d;
  logic [Q-1:0]          buf_set, buf_set_d;
  logic [CW-1:0]         cnt, cnt_d;

  logic                  wsb_d;
  logic [BW*Q-1:0]       wdata_d;
  logic [Q-1:0]          bytemask_d;
  logic [ADDR_SPACE-1:0] waddr_d;
  logic                  flush_done_d;

  logic                  accept;
  logic [ADDR_SPACE-1:0] in_word;
  logic [LW-1:0]         in_lane;
  logic                  same_word;
  logic                  timeout_hit;
  logic [BW*Q-1:0]       base_data, merged_data;
  logic [Q-1:0]          base_set, merged_set;

  assign in_ready  = ~flush;
  assign accept    = in_valid & ~flush;
  assign in_word   = in_idx[IW-1:LW];
  assign in_lane   = in_idx[LW-1:0];
  assign same_word = (in_word == buf_word);
  assign pending   = (state == ACCUM);

  assign timeout_hit = (TIMEOUT != 0) &&
                       (cnt == CW'(TIMEOUT - 1));

  // Merge into the live buffer only when extending the same word;
  // otherwise start from an empty image so stale lanes read as 0.
  assign base_data = (pending && same_word) ? buf_data : '0;
  assign base_set  = (pending && same_word) ? buf_set  : '0;

  next_lane_merge #(
    .Q  (Q),
    .BW (BW)
  ) u_merge (
    .cur_data (base_data),
    .cur_set  (base_set),
    .lane     (in_lane),
    .value    (in_data),
    .new_data (merged_data),
    .new_set  (merged_set)
  );

  // Next-state, buffer update and write emission.
  always_comb begin
    state_d      = state;
    buf_word_d   = buf_word;
    buf_data_d   = buf_data;
    buf_set_d    = buf_set;
    cnt_d        = cnt;
    wsb_d        = 1'b1;
    bytemask_d   = '1;
    wdata_d      = wdata;
    waddr_d      = waddr;
    flush_done_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          buf_word_d = in_word;
          buf_data_d = merged_data;
          buf_set_d  = merged_set;
          cnt_d      = '0;
          state_d    = ACCUM;
        end else if (flush) begin
          flush_done_d = 1'b1;
        end
      end
      ACCUM: begin
        if (flush || (!accept && timeout_hit) ||
            (accept && !same_word)) begin
          wsb_d      = 1'b0;
          wdata_d    = buf_data;
          waddr_d    = buf_word;
          bytemask_d = ~buf_set;
        end
        if (flush) begin
          flush_done_d = 1'b1;
          buf_data_d   = '0;
          buf_set_d    = '0;
          state_d      = IDLE;
        end else if (accept) begin
          buf_word_d = in_word;
          buf_data_d = merged_data;
          buf_set_d  = merged_set;
          cnt_d      = '0;
        end else if (timeout_hit) begin
          buf_data_d = '0;
          buf_set_d  = '0;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Buffer, idle counter and registered SRAM-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_word   <= '0;
      buf_data   <= '0;
      buf_set    <= '0;
      cnt        <= '0;
      wsb        <= 1'b1;
      wdata      <= '0;
      bytemask   <= '1;
      waddr      <= '0;
      flush_done <= 1'b0;
    end else begin
      buf_word   <= buf_word_d;
      buf_data   <= buf_data_d;
      buf_set    <= buf_set_d;
      cnt        <= cnt_d;
      wsb        <= wsb_d;
      wdata      <= wdata_d;
      bytemask   <= bytemask_d;
      waddr      <= waddr_d;
      flush_done <= flush_done_d;
    end
  end

endmodule
